// File: rtl/bill_settle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bill_settle_pkg
// Description : Shared types and constants for the washer billing stage:
//               FSM state encoding, wash mode codes, BCD digit type,
//               7-segment glyphs {dp,g,f,e,d,c,b,a} and small BCD helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package bill_settle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ADD  = 3'd2,
    ST_SUB  = 3'd3,
    ST_NEG  = 3'd4,
    ST_SHOW = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  localparam logic [2:0] c_MODE_DRY    = 3'd0;
  localparam logic [2:0] c_MODE_SMALL  = 3'd1;
  localparam logic [2:0] c_MODE_MEDIUM = 3'd2;
  localparam logic [2:0] c_MODE_BIG    = 3'd3;

  typedef logic [3:0] bcd_t;

  localparam logic [7:0] c_SEG_0     = 8'h3F;
  localparam logic [7:0] c_SEG_1     = 8'h06;
  localparam logic [7:0] c_SEG_2     = 8'h5B;
  localparam logic [7:0] c_SEG_3     = 8'h4F;
  localparam logic [7:0] c_SEG_4     = 8'h66;
  localparam logic [7:0] c_SEG_5     = 8'h6D;
  localparam logic [7:0] c_SEG_6     = 8'h7D;
  localparam logic [7:0] c_SEG_7     = 8'h07;
  localparam logic [7:0] c_SEG_8     = 8'h7F;
  localparam logic [7:0] c_SEG_9     = 8'h6F;
  localparam logic [7:0] c_SEG_C     = 8'h39;
  localparam logic [7:0] c_SEG_DASH  = 8'h40;
  localparam logic [7:0] c_SEG_BLANK = 8'h00;

  function automatic logic [7:0] seg7(input bcd_t d);
    logic [7:0] g;
    case (d)
      4'd0:    g = c_SEG_0;
      4'd1:    g = c_SEG_1;
      4'd2:    g = c_SEG_2;
      4'd3:    g = c_SEG_3;
      4'd4:    g = c_SEG_4;
      4'd5:    g = c_SEG_5;
      4'd6:    g = c_SEG_6;
      4'd7:    g = c_SEG_7;
      4'd8:    g = c_SEG_8;
      4'd9:    g = c_SEG_9;
      default: g = c_SEG_BLANK;
    endcase
    return g;
  endfunction

  // Digit 0 = units, 1 = tens, 2 = hundreds.
  function automatic bcd_t bcd_pick(input logic [11:0] v, input logic [1:0] idx);
    bcd_t d;
    case (idx)
      2'd0:    d = v[3:0];
      2'd1:    d = v[7:4];
      default: d = v[11:8];
    endcase
    return d;
  endfunction

  function automatic logic [11:0] bcd_put(input logic [11:0] v, input logic [1:0] idx,
                                          input bcd_t d);
    logic [11:0] r;
    r = v;
    case (idx)
      2'd0:    r[3:0]  = d;
      2'd1:    r[7:4]  = d;
      default: r[11:8] = d;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_alu.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_alu
// Description : One BCD digit adder/subtractor with carry/borrow chaining.
//               Shared serially across units/tens/hundreds by bill_settle.
// Ports       : a, b   - BCD operand digits
//               cin    - carry in (add) or borrow in (sub)
//               sub    - 1 = a - b - cin, 0 = a + b + cin
//               y      - BCD result digit
//               cout   - carry out (add) or borrow out (sub)
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_alu
  import bill_settle_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       sub,
  output logic [3:0] y,
  output logic       cout
);

  logic [4:0] w_sum;
  logic [4:0] w_diff;
  bcd_t       w_y_add;
  bcd_t       w_y_sub;

  always_comb begin
    w_sum   = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    w_diff  = {1'b0, a} - {1'b0, b} - {4'd0, cin};
    // Sum peaks at 19 and difference bottoms at -10, so 5 bits suffice and
    // a single +/-10 correction brings either back into 0..9.
    w_y_add = (w_sum > 5'd9) ? 4'(w_sum - 5'd10) : w_sum[3:0];
    w_y_sub = w_diff[4] ? 4'(w_diff + 5'd10) : w_diff[3:0];
    if (sub) begin
      y    = w_y_sub;
      cout = w_diff[4];
    end else begin
      y    = w_y_add;
      cout = (w_sum > 5'd9);
    end
  end

endmodule
`default_nettype wire

// File: rtl/bill_settle.sv
`default_nettype none
// ============================================================================
// Module      : bill_settle
// Description : Washer billing stage. Computes charge = price (+ overtime
//               fine), deducts it from the BCD balance digit-serially and
//               shows charge / new balance on a 4-digit multiplexed display.
//               Build option: define BILL_FINE_EN to add the late fine;
//               otherwise late/setfine are ignored.
// Ports       : clk, rst (async, active-low), en (stage active level),
//               m_pos/u_pos/d_pos (button pulses), bal_in, mode,
//               dy/s/m/b_price, setfine, late (BCD inputs),
//               led/ena (display), st_light (lamps), bal_out/bal_neg
//               (new balance), next (billing complete level).
// Revision    : 1.0 - initial release
// ============================================================================
module bill_settle
  import bill_settle_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        m_pos,
  input  logic        u_pos,
  input  logic        d_pos,
  input  logic [11:0] bal_in,
  input  logic [2:0]  mode,
  input  logic [11:0] dy_price,
  input  logic [11:0] s_price,
  input  logic [11:0] m_price,
  input  logic [11:0] b_price,
  input  logic [11:0] setfine,
  input  logic        late,
  output logic [7:0]  led,
  output logic [3:0]  ena,
  output logic [7:0]  st_light,
  output logic [11:0] bal_out,
  output logic        bal_neg,
  output logic        next
);

  localparam int c_DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [11:0]        r_bal;
  logic [11:0]        r_price;
  logic [11:0]        r_fine;
  logic [11:0]        r_charge;
  logic [11:0]        r_bal_out;
  logic [7:0]         r_tmp;
  logic [1:0]         r_idx;
  logic [1:0]         r_digit;
  logic [c_DIV_W-1:0] r_div;
  logic               r_carry;
  logic               r_late;
  logic               r_err;
  logic               r_sat;
  logic               r_neg;
  logic               r_page;

  logic [11:0]        w_price_sel;
  logic [11:0]        w_fine_sel;
  logic               w_late_sel;
  logic               w_mode_err;
  logic [3:0]         w_a;
  logic [3:0]         w_b;
  logic [3:0]         w_y;
  logic               w_cin;
  logic               w_sub;
  logic               w_cout;
  logic               w_last;
  logic               w_shown;

  // ---------------------------------------------------------------- inputs
  always_comb begin
    w_price_sel = 12'h000;
    case (mode)
      c_MODE_DRY:    w_price_sel = dy_price;
      c_MODE_SMALL:  w_price_sel = s_price;
      c_MODE_MEDIUM: w_price_sel = m_price;
      c_MODE_BIG:    w_price_sel = b_price;
      default:       w_price_sel = 12'h000;
    endcase
  end
  assign w_mode_err = (mode > c_MODE_BIG);

`ifdef BILL_FINE_EN
  assign w_fine_sel = late ? setfine : 12'h000;
  assign w_late_sel = late;
`else
  // Fine disabled: adding zero keeps the ADD phase, and so the latency, intact.
  logic w_unused_fine;
  assign w_fine_sel    = 12'h000;
  assign w_late_sel    = 1'b0;
  assign w_unused_fine = ^{late, setfine};
`endif

  // ------------------------------------------------------------ digit ALU
  assign w_last = (r_idx == 2'd2);
  assign w_cin  = (r_idx == 2'd0) ? 1'b0 : r_carry;

  always_comb begin
    w_a   = 4'd0;
    w_b   = 4'd0;
    w_sub = 1'b0;
    case (r_state)
      ST_ADD: begin
        w_a = bcd_pick(r_price, r_idx);
        w_b = bcd_pick(r_fine, r_idx);
      end
      ST_SUB: begin
        w_a   = bcd_pick(r_bal, r_idx);
        w_b   = bcd_pick(r_charge, r_idx);
        w_sub = 1'b1;
      end
      ST_NEG: begin
        w_a   = bcd_pick(r_charge, r_idx);
        w_b   = bcd_pick(r_bal, r_idx);
        w_sub = 1'b1;
      end
      default: ;
    endcase
  end

  bcd_digit_alu u_alu (
    .a    (w_a),
    .b    (w_b),
    .cin  (w_cin),
    .sub  (w_sub),
    .y    (w_y),
    .cout (w_cout)
  );

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_LOAD;
        ST_LOAD: w_state_nxt = ST_ADD;
        ST_ADD:  if (w_last) w_state_nxt = ST_SUB;
        ST_SUB:  if (w_last) w_state_nxt = w_cout ? ST_NEG : ST_SHOW;
        ST_NEG:  if (w_last) w_state_nxt = ST_SHOW;
        ST_SHOW: if (m_pos)  w_state_nxt = ST_DONE;
        ST_DONE: w_state_nxt = ST_DONE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bal     <= 12'h000;
      r_price   <= 12'h000;
      r_fine    <= 12'h000;
      r_charge  <= 12'h000;
      r_bal_out <= 12'h000;
      r_tmp     <= 8'h00;
      r_idx     <= 2'd0;
      r_carry   <= 1'b0;
      r_late    <= 1'b0;
      r_err     <= 1'b0;
      r_sat     <= 1'b0;
      r_neg     <= 1'b0;
      r_page    <= 1'b0;
    end else begin
      r_carry <= w_cout;
      if (w_state_nxt == ST_IDLE) begin
        // Abort / leave: everything visible goes back to zero next cycle.
        r_charge  <= 12'h000;
        r_bal_out <= 12'h000;
        r_idx     <= 2'd0;
        r_late    <= 1'b0;
        r_err     <= 1'b0;
        r_sat     <= 1'b0;
        r_neg     <= 1'b0;
        r_page    <= 1'b0;
      end else begin
        if ((r_state == ST_ADD || r_state == ST_SUB || r_state == ST_NEG) && !w_last)
          r_idx <= r_idx + 2'd1;
        else
          r_idx <= 2'd0;

        case (r_state)
          ST_LOAD: begin
            r_bal     <= bal_in;
            r_price   <= w_price_sel;
            r_fine    <= w_fine_sel;
            r_late    <= w_late_sel;
            r_err     <= w_mode_err;
            r_sat     <= 1'b0;
            r_neg     <= 1'b0;
            r_charge  <= 12'h000;
            r_bal_out <= 12'h000;
          end
          ST_ADD: begin
            r_charge <= bcd_put(r_charge, r_idx, w_y);
            if (w_last && w_cout) begin
              r_charge <= 12'h999;
              r_sat    <= 1'b1;
            end
          end
          ST_SUB: begin
            if (r_idx == 2'd0) r_tmp[3:0] <= w_y;
            else if (r_idx == 2'd1) r_tmp[7:4] <= w_y;
            else if (!w_cout) begin
              r_bal_out <= {w_y, r_tmp};
              r_neg     <= 1'b0;
            end
          end
          ST_NEG: begin
            if (r_idx == 2'd0) r_tmp[3:0] <= w_y;
            else if (r_idx == 2'd1) r_tmp[7:4] <= w_y;
            else begin
              r_bal_out <= {w_y, r_tmp};
              r_neg     <= 1'b1;
            end
          end
          ST_SHOW: begin
            // Confirm wins over page selection in the same cycle.
            if (!m_pos) begin
              if (u_pos)      r_page <= 1'b0;
              else if (d_pos) r_page <= 1'b1;
            end
          end
          default: ;
        endcase

        if (w_state_nxt == ST_SHOW && r_state != ST_SHOW)
          r_page <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------- display scan
  assign w_shown = (r_state == ST_SHOW) || (r_state == ST_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div   <= '0;
      r_digit <= 2'd0;
    end else if (w_shown) begin
      if (r_div == c_DIV_W'(REFRESH_DIV - 1)) begin
        r_div   <= '0;
        r_digit <= r_digit + 2'd1;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end else begin
      r_div   <= '0;
      r_digit <= 2'd0;
    end
  end

  always_comb begin
    ena = 4'b0000;
    led = c_SEG_BLANK;
    if (w_shown) begin
      ena = 4'b0001 << r_digit;
      if (r_digit == 2'd3)
        led = r_page ? (r_neg ? c_SEG_DASH : c_SEG_BLANK) : c_SEG_C;
      else
        led = seg7(bcd_pick(r_page ? r_bal_out : r_charge, r_digit));
    end
  end

  // --------------------------------------------------------------- status
  assign st_light = {1'b0, r_sat, r_err, r_late, r_neg,
                     (r_state == ST_DONE), (r_state == ST_SHOW),
                     (r_state == ST_LOAD || r_state == ST_ADD ||
                      r_state == ST_SUB  || r_state == ST_NEG)};
  assign bal_out  = r_bal_out;
  assign bal_neg  = r_neg;
  assign next     = (r_state == ST_DONE);

endmodule
`default_nettype wire
